// File: rtl/div_10by5_seq.sv
// div_10by5_seq: 10-bit / 5-bit unsigned restoring divider, one quotient bit per clock, MSB first.
// Optional DIV_ZERO_CHECK_EN: a zero divisor skips the iterations and reports div_by_zero with done.
`timescale 1ns/1ps
module div_10by5_seq #(
  parameter int DW = 10,
  parameter int VW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int            CW   = 4;
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [DW-1:0] r_d;
  logic [VW-1:0] r_v;
  logic [VW-1:0] r_p;
  logic [CW-1:0] r_count;
  logic [DW-1:0] r_quotient;
  logic [VW-1:0] r_remainder;
  logic          r_div_by_zero;

  logic          w_accept;
  logic          w_zero_short;
  logic          w_last;
  logic [VW:0]   w_p_shift;
  logic          w_q_bit;
  logic [VW-1:0] w_p_next;
  logic [DW-1:0] w_d_next;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_count == LAST);

`ifdef DIV_ZERO_CHECK_EN
  assign w_zero_short = w_accept && (divisor == '0);
`else
  assign w_zero_short = 1'b0;
`endif

  // The stored partial remainder is always below the divisor, so its 6th bit is
  // only ever needed transiently in the shifted value used for the compare.
  assign w_p_shift = {r_p, r_d[DW-1]};
  assign w_q_bit   = (w_p_shift >= {1'b0, r_v});
  assign w_p_next  = w_q_bit ? (w_p_shift[VW-1:0] - r_v) : w_p_shift[VW-1:0];
  assign w_d_next  = {r_d[DW-2:0], w_q_bit};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: the default is assigned before the case so no path leaves the
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = w_zero_short ? S_DONE : S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_d     <= '0;
      r_v     <= '0;
      r_p     <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_d     <= dividend;
      r_v     <= divisor;
      r_p     <= '0;
      r_count <= '0;
    end else if (r_state == S_RUN) begin
      r_d <= w_d_next;
      r_p <= w_p_next;
      if (!w_last) r_count <= r_count + 1'b1;
    end
  end

  // Results load only on entry to DONE and hold until the next completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else if (w_zero_short) begin
      r_quotient    <= '1;
      r_remainder   <= dividend[VW-1:0];
      r_div_by_zero <= 1'b1;
    end else if ((r_state == S_RUN) && w_last) begin
      r_quotient    <= w_d_next;
      r_remainder   <= w_p_next;
      r_div_by_zero <= 1'b0;
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule

// File: doc/div_10by5_seq.md
# div_10by5_seq

Sequential restoring divider that divides a 10-bit unsigned dividend by a 5-bit unsigned divisor. It produces one quotient bit per clock, MSB first, and is the inverse companion of the team's 5-bit shift-and-add multiplier. A product from that multiplier can be fed back here to recover the original operand. The block sits in the same arithmetic datapath and uses a start/busy/done handshake toward its controller.

## Interface
- `DW`, 10, dividend and quotient width (fixed at 10; no other value is supported).
- `VW`, 5, divisor and remainder width (fixed at 5).
- `clk`  in  1  single clock, rising-edge.
- `reset`  in  1  asynchronous, active-high reset. It clears all state and outputs immediately.
- `start`  in  1  request. Sampled only when `busy`=0.
- `dividend`  in  10  unsigned numerator. Sampled on the accepting edge.
- `divisor`  in  5  unsigned denominator. Sampled on the accepting edge.
- `busy`  out  1  high while a division is in flight, including the DONE cycle.
- `done`  out  1  single-cycle pulse. Indicates `quotient` and `remainder` are valid.
- `quotient`  out  10  result. Held until the next `done`.
- `remainder`  out  5  result. Held until the next `done`.
- `div_by_zero`  out  1  zero-divisor flag, valid with `done`. Present only with `DIV_ZERO_CHECK_EN`; otherwise tied 0.

## Operation
- States:
  - IDLE → RUN on `start`=1.
  - RUN stays in RUN while `count`<9.
  - RUN → DONE when the iteration with `count`=9 completes.
  - DONE → IDLE unconditionally.
- Accept (IDLE, `start`=1): latch `dividend` into shift register D and `divisor` into V. Clear the 6-bit partial remainder P. Set `count`=0.
- RUN iteration i (`count` = i, 0..9):
  - P' = {P[4:0], D[9]}; shift D left by one.
  - If P' ≥ {1'b0, V}: P = P' − V and the new quotient bit is 1.
  - Otherwise P = P' and the new quotient bit is 0.
  - Quotient bits shift into D's LSB, so D holds the quotient after 10 iterations.
- DONE: `quotient` = D, `remainder` = P[4:0], `done` = 1 for exactly this cycle.
- Arithmetic:
  - Invariant: `dividend` = `quotient`·`divisor` + `remainder`, with `remainder` < `divisor` for every nonzero divisor.
  - P never exceeds 6 bits; the compare uses 6-bit unsigned values.
- Zero divisor, natural algorithm: result is `quotient`=10'h3FF, `remainder`=`dividend`[4:0].
- `start` while `busy`=1 (RUN or DONE) is ignored. The operand inputs are don't-care then.
- Back-to-back operation: `start` may be asserted in the cycle after `done`, when the block is back in IDLE.
- Outputs are registered. `quotient` and `remainder` update only on entry to DONE and are otherwise held.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, `count`=0.
- Reset asserted mid-operation aborts immediately. No `done` is produced for the aborted request.
- Accepting edge k: `busy` rises after edge k.
- Iterations run on edges k+1 … k+10. The block enters DONE at edge k+10.
- `done` is high between edges k+10 and k+11, with results valid in that same cycle.
- `busy` falls after edge k+11.
- Latency from the accepting edge to `done`: 10 cycles. Initiation interval: 12 cycles.

## Configuration
- `DIV_ZERO_CHECK_EN` defined:
  - On the accepting edge, `divisor`==0 sends IDLE directly to DONE.
  - `done` is high between edges k and k+1, with `quotient`=10'h3FF, `remainder`=`dividend`[4:0] and `div_by_zero`=1.
  - `div_by_zero`=0 for every nonzero-divisor result.
- `DIV_ZERO_CHECK_EN` not defined:
  - No zero-divisor special case; the zero-divisor result follows the natural algorithm with full 10-cycle latency.
  - `div_by_zero` is constant 0.

## Test plan
- 1023 / 31 → `quotient`=33, `remainder`=0; `done` exactly 10 cycles after the accepting edge.
- 100 / 7 → 14 r 2. Then a second `start` in the cycle after `done`: 5 / 9 → 0 r 5, with no lost or duplicated `done`.
- 1000 / 1 → 1000 r 0. Then `start`=1 held high for 5 cycles while `busy` with different operands → ignored; results unchanged.
- Divisor 0 with dividend 10'h2A5 → `quotient`=10'h3FF, `remainder`=5'h05.
  - With `DIV_ZERO_CHECK_EN`: `done` after 0 cycles and `div_by_zero`=1.
  - Without it: `done` after 10 cycles and `div_by_zero`=0.
- `reset` pulsed asynchronously between clock edges during RUN at iteration 4 → all outputs 0 immediately and no `done`. A following 600 / 25 → 24 r 0.
- Random sweep of 2000 nonzero-divisor cases checking `dividend` = q·d + r and r < d.
